// File: rtl/alu_reservation_station_if.sv
// Dispatch, CDB snoop and issue signals between the
// ALU reservation station and its neighbours.
interface alu_reservation_station_if;
    logic        dispatch_valid_in;
    logic [3:0]  dispatch_aluFunc_in;
    logic [2:0]  dispatch_rob_idx_in;
    logic [31:0] dispatch_rval1_in;
    logic [31:0] dispatch_rval2_in;
    logic        dispatch_rdy1_in;
    logic        dispatch_rdy2_in;
    logic [2:0]  dispatch_tag1_in;
    logic [2:0]  dispatch_tag2_in;
    logic        full_out;
    logic        cdb_valid_in;
    logic [2:0]  cdb_rob_idx_in;
    logic [31:0] cdb_data_in;
    logic        alu_busy_in;
    logic        issue_valid_out;
    logic [31:0] issue_rval1_out;
    logic [31:0] issue_rval2_out;
    logic [3:0]  issue_aluFunc_out;
    logic [2:0]  issue_rob_idx_out;

    modport slave (
        input  dispatch_valid_in, dispatch_aluFunc_in,
        input  dispatch_rob_idx_in,
        input  dispatch_rval1_in, dispatch_rval2_in,
        input  dispatch_rdy1_in, dispatch_rdy2_in,
        input  dispatch_tag1_in, dispatch_tag2_in,
        input  cdb_valid_in, cdb_rob_idx_in, cdb_data_in,
        input  alu_busy_in,
        output full_out,
        output issue_valid_out,
        output issue_rval1_out, issue_rval2_out,
        output issue_aluFunc_out, issue_rob_idx_out
    );

    modport master (
        output dispatch_valid_in, dispatch_aluFunc_in,
        output dispatch_rob_idx_in,
        output dispatch_rval1_in, dispatch_rval2_in,
        output dispatch_rdy1_in, dispatch_rdy2_in,
        output dispatch_tag1_in, dispatch_tag2_in,
        output cdb_valid_in, cdb_rob_idx_in, cdb_data_in,
        output alu_busy_in,
        input  full_out,
        input  issue_valid_out,
        input  issue_rval1_out, issue_rval2_out,
        input  issue_aluFunc_out, issue_rob_idx_out
    );
endinterface

// File: rtl/alu_reservation_station.sv
// Collapsing-queue reservation station for the ALU: buffers
// dispatched ops, snoops the CDB, issues the oldest ready one.
module alu_reservation_station #(
    parameter int DEPTH = 4
) (
    input logic clk_in,
    input logic rst_in,
    input logic flush_in,
    alu_reservation_station_if.slave bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);

    typedef struct packed {
        logic [3:0]  func;
        logic [2:0]  rob;
        logic        rdy1;
        logic [2:0]  tag1;
        logic [31:0] val1;
        logic        rdy2;
        logic [2:0]  tag2;
        logic [31:0] val2;
    } ent_t;

    ent_t        ent_q [DEPTH];
    ent_t        ent_d [DEPTH];
    ent_t        snp   [DEPTH];
    ent_t        new_e;
    logic [CW-1:0] count_q, count_d, cnt_iss;
    logic [IW-1:0] sel;
    logic        have_sel, do_issue, accept, full;
    logic        iss_valid_q, iss_valid_d;
    logic [3:0]  iss_func_q, iss_func_d;
    logic [2:0]  iss_rob_q, iss_rob_d;
    logic [31:0] iss_v1_q, iss_v1_d;
    logic [31:0] iss_v2_q, iss_v2_d;

    assign full = (count_q == CW'(DEPTH));

    // Oldest ready entry, judged on pre-edge state
    always_comb begin
        sel      = '0;
        have_sel = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!have_sel && CW'(i) < count_q &&
                ent_q[i].rdy1 && ent_q[i].rdy2) begin
                sel      = IW'(i);
                have_sel = 1'b1;
            end
        end
        do_issue = have_sel && !bus.alu_busy_in && !flush_in;
        accept   = bus.dispatch_valid_in && !full && !flush_in;
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            snp[i] = ent_q[i];
            if (bus.cdb_valid_in && !snp[i].rdy1 &&
                snp[i].tag1 == bus.cdb_rob_idx_in) begin
                snp[i].rdy1 = 1'b1;
                snp[i].val1 = bus.cdb_data_in;
            end
            if (bus.cdb_valid_in && !snp[i].rdy2 &&
                snp[i].tag2 == bus.cdb_rob_idx_in) begin
                snp[i].rdy2 = 1'b1;
                snp[i].val2 = bus.cdb_data_in;
            end
        end
    end

    always_comb begin
        new_e.func = bus.dispatch_aluFunc_in;
        new_e.rob  = bus.dispatch_rob_idx_in;
        new_e.tag1 = bus.dispatch_tag1_in;
        new_e.tag2 = bus.dispatch_tag2_in;
        new_e.rdy1 = bus.dispatch_rdy1_in;
        new_e.val1 = bus.dispatch_rval1_in;
        new_e.rdy2 = bus.dispatch_rdy2_in;
        new_e.val2 = bus.dispatch_rval2_in;
        // Same-cycle CDB result bypasses into the new entry
        if (!bus.dispatch_rdy1_in && bus.cdb_valid_in &&
            bus.dispatch_tag1_in == bus.cdb_rob_idx_in) begin
            new_e.rdy1 = 1'b1;
            new_e.val1 = bus.cdb_data_in;
        end
        if (!bus.dispatch_rdy2_in && bus.cdb_valid_in &&
            bus.dispatch_tag2_in == bus.cdb_rob_idx_in) begin
            new_e.rdy2 = 1'b1;
            new_e.val2 = bus.cdb_data_in;
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_d[i] = snp[i];
        end
        if (do_issue) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                if (IW'(i) >= sel) begin
                    ent_d[i] = snp[i + 1];
                end
            end
        end
        cnt_iss = count_q - CW'(do_issue);
        if (accept) begin
            ent_d[cnt_iss[IW-1:0]] = new_e;
        end
        count_d = flush_in ? '0 : cnt_iss + CW'(accept);
    end

    always_comb begin
        iss_valid_d = do_issue;
        iss_func_d  = iss_func_q;
        iss_rob_d   = iss_rob_q;
        iss_v1_d    = iss_v1_q;
        iss_v2_d    = iss_v2_q;
        if (do_issue) begin
            iss_func_d = ent_q[sel].func;
            iss_rob_d  = ent_q[sel].rob;
            iss_v1_d   = ent_q[sel].val1;
            iss_v2_d   = ent_q[sel].val2;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            count_q     <= '0;
            iss_valid_q <= 1'b0;
            iss_func_q  <= '0;
            iss_rob_q   <= '0;
            iss_v1_q    <= '0;
            iss_v2_q    <= '0;
        end else begin
            count_q     <= count_d;
            iss_valid_q <= iss_valid_d;
            iss_func_q  <= iss_func_d;
            iss_rob_q   <= iss_rob_d;
            iss_v1_q    <= iss_v1_d;
            iss_v2_q    <= iss_v2_d;
        end
    end

    // Payload needs no reset: validity comes from count_q
    always_ff @(posedge clk_in) begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_q[i] <= ent_d[i];
        end
    end

    assign bus.full_out          = full;
    assign bus.issue_valid_out   = iss_valid_q;
    assign bus.issue_aluFunc_out = iss_func_q;
    assign bus.issue_rob_idx_out = iss_rob_q;
    assign bus.issue_rval1_out   = iss_v1_q;
    assign bus.issue_rval2_out   = iss_v2_q;
endmodule

// File: doc/alu_reservation_station.md
# alu_reservation_station

Issue-side front end for one `alu` functional unit in the superscalar core. Buffers up to DEPTH dispatched ALU micro-ops, captures missing source operands by snooping the common data bus (CDB), and issues the oldest fully ready entry to the ALU whenever the ALU is not busy. It drives the ALU's operand, function and ROB-index inputs and consumes its `busy_out`.

## Interface
- DEPTH, 4: number of entries (2..8).
- clk_in  input  1  clock; all state updates on the rising edge.
- rst_in  input  1  reset, synchronous, active-high.
- flush_in  input  1  synchronous squash of all entries (mispredict).
- dispatch_valid_in  input  1  dispatch request this cycle.
- dispatch_aluFunc_in  input  4  AluFunc encoding (Add..Sra, types.svh).
- dispatch_rob_idx_in  input  3  destination ROB index.
- dispatch_rval1_in / dispatch_rval2_in  input  32  operand values, meaningful when the matching ready bit is 1.
- dispatch_rdy1_in / dispatch_rdy2_in  input  1  operand already available.
- dispatch_tag1_in / dispatch_tag2_in  input  3  producing ROB index when not ready.
- full_out  output  1  no free entry; dispatch is ignored.
- cdb_valid_in  input  1  CDB broadcast valid.
- cdb_rob_idx_in  input  3  ROB index of the broadcast result.
- cdb_data_in  input  32  broadcast result value.
- alu_busy_in  input  1  ALU `busy_out`; no issue while high.
- issue_valid_out  output  1  one-cycle pulse: issue_* fields are valid for the ALU.
- issue_rval1_out / issue_rval2_out  output  32  operands to ALU `rval1_in` / `rval2_in`.
- issue_aluFunc_out  output  4  to ALU `aluFunc_in`.
- issue_rob_idx_out  output  3  to ALU `rob_idx`.

## Operation
- Storage is a collapsing queue. Positions 0..count-1 are valid, and position 0 is the oldest. Each entry holds func, rob_idx, and per operand {rdy, tag, val}.
- Dispatch is accepted when dispatch_valid_in && !full_out && !flush_in. The new entry is written at the youngest position after any same-cycle collapse.
- CDB snoop (every edge):
  - Every valid entry operand with rdy=0 and tag==cdb_rob_idx_in captures cdb_data_in and sets rdy=1.
  - A dispatching operand with rdy=0 whose tag matches a same-cycle CDB broadcast is stored already ready, with the CDB value.
- Issue selection at each edge:
  - Candidates are stored entries with both rdy bits set, using register state before this edge's updates.
  - If !alu_busy_in and a candidate exists, the lowest-position (oldest) candidate is copied into the issue_* registers and issue_valid_out=1.
  - The issued entry is removed and younger entries shift down one position.
  - Otherwise issue_valid_out=0 and the issue_* data registers hold their values.
- full_out = (count==DEPTH), derived from registered count. A dispatch arriving while full_out=1 is dropped, even if an issue frees an entry that same edge. The dispatcher must stall.
- Same-cycle dispatch, issue and CDB are all legal. Count update: +1 for an accepted dispatch, -1 for an issue.
- Flush clears all valid bits and issue_valid_out at that edge. A dispatch in the same cycle is ignored. A CDB broadcast in the same cycle has no effect.
- Reset behaves identically to flush and also zeroes the issue_* data registers.
- Operands are stored as raw 32-bit values. The block performs no arithmetic; the ALU defines signedness.

## Timing
- Reset values: issue_valid_out=0, issue_rval1_out=0, issue_rval2_out=0, issue_aluFunc_out=0, issue_rob_idx_out=0, full_out=0, count=0.
- Minimum latency, both operands ready at dispatch: dispatch sampled at edge E0, issue_valid_out high after E1.
- Operand woken by CDB at edge Ek: the entry is issuable at Ek+1, and issue_valid_out is high after Ek+1.
- A dispatch-time CDB bypass gives the same minimum latency as ready-at-dispatch.
- issue_valid_out is never high in two consecutive cycles unless alu_busy_in was low at both edges. Throughput is up to one issue per cycle.
- alu_busy_in is sampled at the issuing edge only.

## Test plan
1. Reset, then dispatch Add rob=2, r1=5, r2=7 (both ready), busy=0 → issue_valid_out pulses 1 cycle after the dispatch edge with rval1=5, rval2=7, func=Add, rob=2. full_out stays 0.
2. Dispatch Sub rob=3, operand 1 waiting on tag 1, then CDB {1, 0xFFFF_FFF0} two cycles later → issue one cycle after the CDB edge with rval1=0xFFFF_FFF0.
3. Dispatch entries A (rob 4, waiting on tag 0) then B (rob 5, ready) → B issues first. After CDB tag 0, A issues. Both in order of readiness, oldest first among ready entries.
4. With DEPTH=4 and alu_busy_in=1, fill 4 entries → full_out=1. A fifth dispatch is dropped. Release busy → 4 issues on consecutive cycles in dispatch order, then full_out=0.
5. Dispatch with tag 6 while the CDB broadcasts {6, 0x1234} in the same cycle → the stored operand is ready and the op issues at minimum latency with 0x1234.
6. With 3 entries stored, assert flush_in in the same cycle as a dispatch and an issue → count=0, no issue pulse, and the dispatch is not stored. Reset asserted mid-fill gives the same result.
